// File: rtl/serial_frame_pkg.sv
// Shared frame definitions for the serial link.
// Used by both the serializer and the receiver.
package serial_frame_pkg;

  localparam int   ADDR_W     = 7;
  localparam int   DATA_W     = 8;
  localparam int   FRAME_BITS = 19;
  localparam logic IDLE_LVL   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// InD/InC synchronizers plus InC rise pulse.
// Flops reset to the idle level so no edge follows reset.
import serial_frame_pkg::*;

module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d,
  input  logic c,
  output logic d_sync,
  output logic c_rise
);

  logic [SYNC_STAGES-1:0] d_q;
  logic [SYNC_STAGES-1:0] c_q;
  logic                   c_prev;

  // shift both lines through matching chains
  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      d_q    <= {SYNC_STAGES{IDLE_LVL}};
      c_q    <= {SYNC_STAGES{IDLE_LVL}};
      c_prev <= IDLE_LVL;
    end else begin
      d_q    <= {d_q[SYNC_STAGES-2:0], d};
      c_q    <= {c_q[SYNC_STAGES-2:0], c};
      c_prev <= c_q[SYNC_STAGES-1];
    end
  end

  assign d_sync = d_q[SYNC_STAGES-1];
  assign c_rise = c_q[SYNC_STAGES-1] & ~c_prev;

endmodule

// File: rtl/serial_frame_receiver.sv
// Deserializes start/addr/ack/data/ack/stop frames into a
// single-entry valid/ready output register.
import serial_frame_pkg::*;

module serial_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CHECK_STOP  = 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              InD,
  input  logic              InC,
  input  logic              Ready,
  input  logic              Clr,
  output logic [ADDR_W-1:0] A_out,
  output logic [DATA_W-1:0] D_out,
  output logic              Valid,
  output logic              Err,
  output logic              Overrun,
  output logic              Busy
);

  localparam int   TW  = $clog2(TIMEOUT_CYC);
  localparam logic CHK = (CHECK_STOP != 0);

  rx_state_t         state;
  logic [3:0]        cnt;
  logic [TW-1:0]     tmo;
  logic [ADDR_W-1:0] a_sr;
  logic [DATA_W-1:0] d_sr;
  logic              bit_d;
  logic              bit_ev;
  logic              timeout;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .d      (InD),
    .c      (InC),
    .d_sync (bit_d),
    .c_rise (bit_ev)
  );

  assign timeout = (state != IDLE) &&
                   (tmo == TW'(TIMEOUT_CYC - 1));

  // frame FSM, stall timer and output register
  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tmo     <= '0;
      a_sr    <= '0;
      d_sr    <= '0;
      A_out   <= '0;
      D_out   <= '0;
      Valid   <= 1'b0;
      Err     <= 1'b0;
      Overrun <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      Err <= 1'b0;
      if (Clr)
        Overrun <= 1'b0;
      if (Valid && Ready)
        Valid <= 1'b0;
      if (timeout) begin
        state <= IDLE;
        Busy  <= 1'b0;
        Err   <= 1'b1;
        cnt   <= '0;
        tmo   <= '0;
      end else if (bit_ev) begin
        tmo <= '0;
        unique case (state)
          IDLE: begin
            if (!bit_d) begin
              state <= ADDR;
              Busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          ADDR: begin
            a_sr <= {a_sr[ADDR_W-2:0], bit_d};
            if (cnt == 4'(ADDR_W - 1)) begin
              cnt   <= '0;
              state <= ACK1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ACK1: state <= DATA;
          DATA: begin
            d_sr <= {d_sr[DATA_W-2:0], bit_d};
            if (cnt == 4'(DATA_W - 1)) begin
              cnt   <= '0;
              state <= ACK2;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ACK2: state <= STOP;
          STOP: begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (CHK && bit_d) begin
              Err <= 1'b1;
            end else if (!Valid || Ready) begin
              A_out <= a_sr;
              D_out <= d_sr;
              Valid <= 1'b1;
            end else begin
              Overrun <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        tmo <= tmo + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver.
// Second instance runs with the stop check disabled.
import serial_frame_pkg::*;

module tb_serial_frame_receiver;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       InD;
  logic       InC;
  logic       Ready;
  logic       Clr;

  logic [6:0] a_out,   a_out1;
  logic [7:0] d_out,   d_out1;
  logic       valid,   valid1;
  logic       err,     err1;
  logic       ovr,     ovr1;
  logic       busy,    busy1;

  int n_run  = 0;
  int n_fail = 0;

  int v_cnt  = 0;
  int e_cnt  = 0;
  int b_cnt  = 0;
  int v1_cnt = 0;
  int e1_cnt = 0;
  logic [6:0] la,  la1;
  logic [7:0] ld,  ld1;

  int v0, e0, b0, v10, e10;

  always #5 clk_in = ~clk_in;

  serial_frame_receiver #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(64),
    .CHECK_STOP (1)
  ) u_dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .InD    (InD),
    .InC    (InC),
    .Ready  (Ready),
    .Clr    (Clr),
    .A_out  (a_out),
    .D_out  (d_out),
    .Valid  (valid),
    .Err    (err),
    .Overrun(ovr),
    .Busy   (busy)
  );

  serial_frame_receiver #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(64),
    .CHECK_STOP (0)
  ) u_dut1 (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .InD    (InD),
    .InC    (InC),
    .Ready  (Ready),
    .Clr    (Clr),
    .A_out  (a_out1),
    .D_out  (d_out1),
    .Valid  (valid1),
    .Err    (err1),
    .Overrun(ovr1),
    .Busy   (busy1)
  );

  // sample outputs mid-cycle, after the posedge has settled
  always @(posedge clk_in) begin
    #2;
    if (valid) v_cnt++;
    if (valid && Ready) begin
      la = a_out;
      ld = d_out;
    end
    if (err)  e_cnt++;
    if (busy) b_cnt++;
    if (valid1) v1_cnt++;
    if (valid1 && Ready) begin
      la1 = a_out1;
      ld1 = d_out1;
    end
    if (err1) e1_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME_BITS-1:0] mk(
    input logic [6:0] a,
    input logic [7:0] d,
    input logic       stop);
    return {1'b0, a, 1'b1, d, 1'b0, stop};
  endfunction

  task automatic send_bit(input logic b);
    InC = 1'b0;
    InD = b;
    repeat (4) @(negedge clk_in);
    InC = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [FRAME_BITS-1:0] f,
                            input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(f[FRAME_BITS-1-i]);
    InD = 1'b1;
  endtask

  task automatic snap();
    v0  = v_cnt;
    e0  = e_cnt;
    b0  = b_cnt;
    v10 = v1_cnt;
    e10 = e1_cnt;
  endtask

  initial begin
    reset_n = 1'b1;
    InD     = 1'b1;
    InC     = 1'b1;
    Ready   = 1'b0;
    Clr     = 1'b0;

    // reset with InC toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      InC = ~InC;
    end
    check("rst_a",     32'(a_out), 32'h0);
    check("rst_d",     32'(d_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err",   32'(err),   32'h0);
    check("rst_ovr",   32'(ovr),   32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    InC = 1'b1;
    InD = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b0;
    snap();
    repeat (10) @(negedge clk_in);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_err",  32'(e_cnt - e0), 32'h0);
    InD = 1'b1;

    // good frame, consumer ready
    Ready = 1'b1;
    snap();
    send_frame(mk(7'h55, 8'hA3, 1'b0), 19);
    repeat (6) @(negedge clk_in);
    check("good_vcyc", 32'(v_cnt - v0), 32'd1);
    check("good_a",    32'(la), 32'h55);
    check("good_d",    32'(ld), 32'hA3);
    check("good_err",  32'(e_cnt - e0), 32'd0);
    check("good_busy", 32'(b_cnt - b0), 32'd144);

    // backpressure and overrun
    Ready = 1'b0;
    send_frame(mk(7'h12, 8'h34, 1'b0), 19);
    repeat (4) @(negedge clk_in);
    check("bp1_valid", 32'(valid), 32'h1);
    check("bp1_ovr",   32'(ovr),   32'h0);
    send_frame(mk(7'h7F, 8'h00, 1'b0), 19);
    repeat (4) @(negedge clk_in);
    check("bp2_valid", 32'(valid), 32'h1);
    check("bp2_a",     32'(a_out), 32'h12);
    check("bp2_d",     32'(d_out), 32'h34);
    check("bp2_ovr",   32'(ovr),   32'h1);
    Clr = 1'b1;
    @(negedge clk_in);
    Clr = 1'b0;
    check("clr_ovr", 32'(ovr), 32'h0);
    Ready = 1'b1;
    @(negedge clk_in);
    check("drain_valid", 32'(valid), 32'h0);
    Ready = 1'b0;

    // consume and commit in the same cycle
    send_frame(mk(7'h21, 8'h43, 1'b0), 19);
    repeat (4) @(negedge clk_in);
    check("sim1_a", 32'(a_out), 32'h21);
    send_frame(mk(7'h6E, 8'hB5, 1'b0), 18);
    InC = 1'b0;
    InD = 1'b0;
    repeat (4) @(negedge clk_in);
    InC = 1'b1;
    repeat (2) @(negedge clk_in);
    Ready = 1'b1;
    @(negedge clk_in);
    Ready = 1'b0;
    InD   = 1'b1;
    check("sim_valid", 32'(valid), 32'h1);
    check("sim_a",     32'(a_out), 32'h6E);
    check("sim_d",     32'(d_out), 32'hB5);
    check("sim_ovr",   32'(ovr),   32'h0);
    @(negedge clk_in);
    Ready = 1'b1;
    repeat (2) @(negedge clk_in);
    check("sim_drain", 32'(valid), 32'h0);

    // bad stop bit
    snap();
    send_frame(mk(7'h0F, 8'hF0, 1'b1), 19);
    repeat (6) @(negedge clk_in);
    check("stop_errcyc", 32'(e_cnt - e0), 32'd1);
    check("stop_vcyc",   32'(v_cnt - v0), 32'd0);
    check("stop_busy",   32'(busy), 32'h0);
    check("nochk_vcyc",  32'(v1_cnt - v10), 32'd1);
    check("nochk_a",     32'(la1), 32'h0F);
    check("nochk_d",     32'(ld1), 32'hF0);
    check("nochk_err",   32'(e1_cnt - e10), 32'd0);

    // stall after 5 bits
    snap();
    send_frame(mk(7'h5A, 8'h00, 1'b0), 4);
    InC = 1'b0;
    InD = 1'b1;
    repeat (4) @(negedge clk_in);
    InC = 1'b1;
    repeat (66) @(negedge clk_in);
    check("tmo_pre_err",  32'(err),  32'h0);
    check("tmo_pre_busy", 32'(busy), 32'h1);
    @(negedge clk_in);
    check("tmo_err",  32'(err),  32'h1);
    check("tmo_busy", 32'(busy), 32'h0);
    @(negedge clk_in);
    check("tmo_errcyc", 32'(e_cnt - e0), 32'd1);
    snap();
    send_frame(mk(7'h33, 8'hCC, 1'b0), 19);
    repeat (6) @(negedge clk_in);
    check("tmo_next_v", 32'(v_cnt - v0), 32'd1);
    check("tmo_next_a", 32'(la), 32'h33);
    check("tmo_next_d", 32'(ld), 32'hCC);

    // reset mid-DATA
    send_frame(mk(7'h01, 8'hFF, 1'b0), 12);
    check("mid_busy", 32'(busy), 32'h1);
    reset_n = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b0;
    @(negedge clk_in);
    snap();
    send_frame(mk(7'h44, 8'h99, 1'b0), 19);
    repeat (6) @(negedge clk_in);
    check("rst_next_v", 32'(v_cnt - v0), 32'd1);
    check("rst_next_a", 32'(la), 32'h44);
    check("rst_next_d", 32'(ld), 32'h99);
    check("rst_next_e", 32'(e_cnt - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Downstream stage of the serial out buffer: deserializes its OutD/OutC frame stream back into a 7-bit address and an 8-bit data byte.
- Presents each completed frame on a single-entry output register with a valid/ready handshake.
- Flags framing errors, stalled-line timeouts and overruns.
- Sits on the receive side of the serial link, feeding parallel consumer logic.

Parameters:
- SYNC_STAGES, 2, flops in the InD/InC synchronizer chain (minimum 2).
- TIMEOUT_CYC, 64, clk_in cycles without an InC rising edge mid-frame before the frame is aborted.
- CHECK_STOP, 1, when 1 a stop bit not equal to 0 is a framing error; when 0 the stop bit is ignored.

Ports:
- clk_in  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-high reset (asserted = 1) despite the name.
- InD  in  1  serial data from the serializer (OutD); idle level is 1.
- InC  in  1  serial bit strobe from the serializer (OutC); a bit is sampled on each InC rising edge.
- Ready  in  1  consumer accepts A_out/D_out when Ready=1 and Valid=1.
- Clr  in  1  synchronous clear of the sticky Overrun flag.
- A_out  out  7  received address.
- D_out  out  8  received data byte.
- Valid  out  1  A_out/D_out hold an unconsumed frame.
- Err  out  1  one-cycle pulse on a framing error or timeout.
- Overrun  out  1  sticky; a completed frame was dropped because the output register was full.
- Busy  out  1  receiver is mid-frame (state not IDLE).

Behaviour:
- Reset values: A_out=0, D_out=0, Valid=0, Err=0, Overrun=0, Busy=0, state=IDLE, bit count=0, timeout count=0. Synchronizer flops reset to 1, so no spurious edge is seen after reset.
- Reset mid-frame: partial frame discarded; all outputs return to reset values immediately.
- Sampling: InD and InC pass through identical SYNC_STAGES-deep chains. A bit event is synchronized InC = 1 with previous synchronized InC = 0; the bit value is the synchronized InD in that same cycle.
- Frame format, MSB first, 19 bits: start(0), A[6:0], ACK1, D[7:0], ACK2, stop(0). ACK slots are ignored, including X/Z values.
- State machine, advancing only on bit events:
  - IDLE: bit=0 goes to ADDR; bit=1 stays in IDLE.
  - ADDR: shift 7 bits, then ACK1.
  - ACK1: one bit, then DATA.
  - DATA: shift 8 bits, then ACK2.
  - ACK2: one bit, then STOP.
  - STOP: on the stop bit, complete the frame and return to IDLE.
  - A 4-bit counter indexes bits within ADDR and DATA.
- Completion: on the STOP bit event with a good stop bit (or CHECK_STOP=0), the frame commits at the next clk_in edge. Valid rises one cycle after the detecting cycle.
- Framing error: stop bit = 1 with CHECK_STOP=1 gives Err=1 for exactly one cycle, drops the frame, leaves Valid unchanged and returns to IDLE.
- Timeout:
  - The counter clears on every bit event and is held at 0 in IDLE.
  - If it reaches TIMEOUT_CYC-1 outside IDLE: Err pulses for one cycle, state returns to IDLE and the partial frame is dropped.
- Handshake: Valid=1 and Ready=1 in a cycle means the frame is consumed and Valid drops next cycle unless a new frame commits in that same cycle. A_out/D_out are stable while Valid=1 and Ready=0.
- Completion with Valid=1 and Ready=1 in the same cycle: the new frame is loaded, Valid stays 1 and Overrun is not set.
- Completion with Valid=1 and Ready=0: the new frame is dropped, the old frame is kept and Overrun sets (sticky).
- Clr=1 clears Overrun next cycle. If Clr and a new overrun occur in the same cycle, the overrun wins and Overrun stays 1.
- Busy = (state != IDLE), registered.
- Timeout and stop error in the same cycle: a single Err pulse.

Decomposition:
- Package serial_frame_pkg:
  - ADDR_W=7, DATA_W=8, FRAME_BITS=19, IDLE_LVL=1'b1.
  - Receiver state enum: IDLE, ADDR, ACK1, DATA, ACK2, STOP.
  - Shared by the serializer and this receiver.
- Sub-module sync_edge_detect: SYNC_STAGES synchronizer for InD/InC plus InC rising-edge pulse, with reset value 1.

Test Plan:
- Reset: assert reset_n=1 for 3 cycles with InC toggling -> A_out=0, D_out=0, Valid=0, Err=0, Overrun=0, Busy=0; release -> no bit event until the first real InC rise.
- Good frame, A=0x55, D=0xA3, InC period 8 clk, Ready=1 -> Busy high from start bit, one-cycle Valid with A_out=0x55, D_out=0xA3, Err never 1.
- Backpressure, Ready=0: frame A=0x12/D=0x34, then A=0x7F/D=0x00 -> Valid held with 0x12/0x34, Overrun=1 after the second stop bit; then Clr=1 -> Overrun=0; then Ready=1 -> Valid=0.
- Simultaneous consume/commit: Ready asserted in the exact commit cycle of a second frame -> Valid stays 1, outputs switch to the second frame, Overrun=0.
- Stop bit sent as 1, CHECK_STOP=1 -> Err=1 for exactly 1 cycle, Valid stays 0, Busy=0; repeat with CHECK_STOP=0 -> frame delivered.
- Stall and reset: InC stops after 5 bits -> Err pulse when the timeout count reaches 63 (TIMEOUT_CYC-1), Busy=0, next good frame received correctly; reset asserted mid-DATA -> Busy=0 immediately and the following frame is received correctly.
